commit_writeback: RTL and testbench

- Consumer end of the commit-stage interface.
- Accepts results tagged with block, destination, commit ID and commit flag, possibly out of commit-ID order.
- Reorders them in a slot table indexed by commit ID and retires strictly in ascending commit-ID order, with wrap-around.
- Results with the commit flag set are narrowed to data_width with saturation and presented to the register-file write port; results with the flag clear retire silently.

---
 rtl/commit_writeback.sv | 149 ++++++++++++++
 tb/tb_commit_writeback.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_writeback.sv
// Commit-stage consumer: reorders tagged results by commit ID and retires them in order,
// narrowing flagged results with saturation onto the register-file write port.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

module commit_writeback #(
    parameter int data_width = 16,
    parameter int n_blocks   = 256,
    parameter int full_width = 2*data_width+8,
    parameter int shift      = data_width-1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(n_blocks)-1:0]   block_in,
    input  logic signed [full_width-1:0]  result_in,
    input  logic [3:0]                    dest_in,
    input  logic [`COMMIT_ID_WIDTH-1:0]   commit_id_in,
    input  logic                          commit_flag_in,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [$clog2(n_blocks)-1:0]   wr_block,
    output logic [3:0]                    wr_dest,
    output logic signed [data_width-1:0]  wr_data,
    output logic                          wr_sat,
    output logic [`COMMIT_ID_WIDTH-1:0]   next_id,
    output logic [15:0]                   sat_count
);

    localparam int BW  = $clog2(n_blocks);
    localparam int IDW = `COMMIT_ID_WIDTH;
    localparam int NS  = 1 << IDW;
    localparam logic signed [full_width-1:0] SAT_MAX = full_width'((2**(data_width-1))-1);
    localparam logic signed [full_width-1:0] SAT_MIN = ~SAT_MAX;

    logic [NS-1:0]                 slotValid_q, slotValid_d;
    logic [BW-1:0]                 slotBlock_q  [NS];
    logic signed [full_width-1:0]  slotResult_q [NS];
    logic [3:0]                    slotDest_q   [NS];
    logic                          slotFlag_q   [NS];

    logic [IDW-1:0]                nextId_q, nextId_d;
    logic                          wrValid_q, wrValid_d;
    logic [BW-1:0]                 wrBlock_q, wrBlock_d;
    logic [3:0]                    wrDest_q, wrDest_d;
    logic [data_width-1:0]         wrData_q, wrData_d;
    logic                          wrSat_q, wrSat_d;
    logic [15:0]                   satCount_q, satCount_d;

    logic                          accept, retire, outFree;
    logic signed [full_width-1:0]  shifted;
    logic [data_width-1:0]         headData;
    logic                          headSat;

    assign in_ready = enable && !slotValid_q[commit_id_in];
    assign accept   = in_valid && in_ready;
    assign outFree  = !wrValid_q || wr_ready;
    assign retire   = enable && slotValid_q[nextId_q] && outFree;

    // Narrowing of the head-of-line result, evaluated before it is loaded into the output register
    always_comb begin
        shifted = slotResult_q[nextId_q] >>> shift;
        headSat = 1'b1;
        if (shifted > SAT_MAX) begin
            headData = {1'b0, {(data_width-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            headData = {1'b1, {(data_width-1){1'b0}}};
        end else begin
            headData = shifted[data_width-1:0];
            headSat  = 1'b0;
        end
    end

    always_comb begin
        slotValid_d = slotValid_q;
        nextId_d    = nextId_q;
        wrValid_d   = wrValid_q;
        wrBlock_d   = wrBlock_q;
        wrDest_d    = wrDest_q;
        wrData_d    = wrData_q;
        wrSat_d     = wrSat_q;
        satCount_d  = satCount_q;
        if (accept) begin
            slotValid_d[commit_id_in] = 1'b1;
        end
        if (retire) begin
            slotValid_d[nextId_q] = 1'b0;
            nextId_d = nextId_q + 1'b1;
            if (slotFlag_q[nextId_q]) begin
                wrValid_d = 1'b1;
                wrBlock_d = slotBlock_q[nextId_q];
                wrDest_d  = slotDest_q[nextId_q];
                wrData_d  = headData;
                wrSat_d   = headSat;
                if (headSat && satCount_q != 16'hFFFF) begin
                    satCount_d = satCount_q + 16'd1;
                end
            end else begin
                wrValid_d = 1'b0;
            end
        end else if (enable && wrValid_q && wr_ready) begin
            wrValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slotValid_q <= '0;
            nextId_q    <= '0;
            wrValid_q   <= 1'b0;
            wrBlock_q   <= '0;
            wrDest_q    <= '0;
            wrData_q    <= '0;
            wrSat_q     <= 1'b0;
            satCount_q  <= '0;
        end else begin
            slotValid_q <= slotValid_d;
            nextId_q    <= nextId_d;
            wrValid_q   <= wrValid_d;
            wrBlock_q   <= wrBlock_d;
            wrDest_q    <= wrDest_d;
            wrData_q    <= wrData_d;
            wrSat_q     <= wrSat_d;
            satCount_q  <= satCount_d;
        end
    end

    // Slot payloads need no reset: the valid bits alone decide whether they are ever read
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            slotBlock_q[commit_id_in]  <= block_in;
            slotResult_q[commit_id_in] <= result_in;
            slotDest_q[commit_id_in]   <= dest_in;
            slotFlag_q[commit_id_in]   <= commit_flag_in;
        end
    end

    assign wr_valid  = wrValid_q;
    assign wr_block  = wrBlock_q;
    assign wr_dest   = wrDest_q;
    assign wr_data   = wrData_q;
    assign wr_sat    = wrSat_q;
    assign next_id   = nextId_q;
    assign sat_count = satCount_q;

endmodule

// File: tb/tb_commit_writeback.sv
// Directed bench for commit_writeback: vector table of results with hand-computed writes,
// plus sequences for reordering, wrap-around, backpressure, enable freeze and mid-stream reset.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

module tb_commit_writeback;

    typedef struct {
        logic [3:0]  id;
        logic        flag;
        logic [7:0]  blk;
        logic [3:0]  dest;
        logic [39:0] res;
        logic [15:0] expData;
        logic        expSat;
    } vec_t;

    typedef struct {
        logic [7:0]  blk;
        logic [3:0]  dest;
        logic [15:0] data;
        logic        sat;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  block_in = '0;
    logic signed [39:0] result_in = '0;
    logic [3:0]  dest_in = '0;
    logic [3:0]  commit_id_in = '0;
    logic        commit_flag_in = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [7:0]  wr_block;
    logic [3:0]  wr_dest;
    logic signed [15:0] wr_data;
    logic        wr_sat;
    logic [3:0]  next_id;
    logic [15:0] sat_count;

    int checks = 0;
    int failures = 0;
    vec_t vecs[13];
    wr_t  wrQ[$];

    commit_writeback dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .result_in(result_in), .dest_in(dest_in),
        .commit_id_in(commit_id_in), .commit_flag_in(commit_flag_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_block(wr_block), .wr_dest(wr_dest), .wr_data(wr_data), .wr_sat(wr_sat),
        .next_id(next_id), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    // A write presented with wr_ready high at the falling edge is consumed at the next rising edge
    always @(negedge clk) begin
        if (!reset && enable && wr_valid && wr_ready)
            wrQ.push_back('{wr_block, wr_dest, wr_data, wr_sat});
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic checkWrite(input string name, input int idx, input logic [7:0] blk,
                              input logic [3:0] dest, input logic [15:0] data, input logic sat);
        if (idx >= wrQ.size()) begin
            checkOutput({name, "_present"}, 40'(wrQ.size()), 40'(idx + 1));
        end else begin
            checkOutput({name, "_blk"},  40'(wrQ[idx].blk),  40'(blk));
            checkOutput({name, "_dest"}, 40'(wrQ[idx].dest), 40'(dest));
            checkOutput({name, "_data"}, 40'(wrQ[idx].data), 40'(data));
            checkOutput({name, "_sat"},  40'(wrQ[idx].sat),  40'(sat));
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wrQ.delete();
    endtask

    task automatic applyStimulus(input logic [3:0] id, input logic flag, input logic [7:0] blk,
                                 input logic [3:0] dest, input logic [39:0] res);
        int n = 0;
        in_valid = 1'b1; commit_id_in = id; commit_flag_in = flag;
        block_in = blk; dest_in = dest; result_in = res;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("send_timeout", 40'(0), 40'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic sendVec(input int i);
        applyStimulus(vecs[i].id, vecs[i].flag, vecs[i].blk, vecs[i].dest, vecs[i].res);
    endtask

    task automatic waitWrites(input int n);
        int c = 0;
        while (wrQ.size() < n && c < 100) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'd0, 1'b1, 8'h11, 4'd1, 40'h0020000000, 16'h4000, 1'b0};
        vecs[1]  = '{4'd1, 1'b1, 8'h22, 4'd2, 40'h0000008000, 16'h0001, 1'b0};
        vecs[2]  = '{4'd2, 1'b1, 8'h33, 4'd3, 40'hFFFFFF8000, 16'hFFFF, 1'b0};
        vecs[3]  = '{4'd2, 1'b1, 8'h44, 4'd4, 40'h0000010000, 16'h0002, 1'b0};
        vecs[4]  = '{4'd0, 1'b1, 8'h55, 4'd5, 40'h0000018000, 16'h0003, 1'b0};
        vecs[5]  = '{4'd1, 1'b1, 8'h66, 4'd6, 40'h003FFF8000, 16'h7FFF, 1'b0};
        vecs[6]  = '{4'd0, 1'b1, 8'h77, 4'd7, 40'h0040000000, 16'h7FFF, 1'b1};
        vecs[7]  = '{4'd1, 1'b1, 8'h88, 4'd8, 40'hFFBFFF8000, 16'h8000, 1'b1};
        vecs[8]  = '{4'd2, 1'b1, 8'h99, 4'd9, 40'hFFC0000000, 16'h8000, 1'b0};
        vecs[9]  = '{4'd0, 1'b1, 8'hA0, 4'hA, 40'h0000050000, 16'h000A, 1'b0};
        vecs[10] = '{4'd1, 1'b1, 8'hA1, 4'hB, 40'h0000058000, 16'h000B, 1'b0};
        vecs[11] = '{4'd2, 1'b1, 8'hA2, 4'hC, 40'h0000060000, 16'h000C, 1'b0};
        vecs[12] = '{4'd3, 1'b1, 8'hA3, 4'hD, 40'h0000068000, 16'h000D, 1'b0};

        repeat (2) @(posedge clk);
        doReset();
        checkOutput("rst_wr_valid",  40'(wr_valid),  40'(0));
        checkOutput("rst_next_id",   40'(next_id),   40'(0));
        checkOutput("rst_sat_count", 40'(sat_count), 40'(0));
        checkOutput("rst_wr_data",   40'(wr_data),   40'(0));
        checkOutput("rst_in_ready",  40'(in_ready),  40'(1));

        // In-order with the two-edge latency on the first result
        in_valid = 1'b1; commit_id_in = vecs[0].id; commit_flag_in = 1'b1;
        block_in = vecs[0].blk; dest_in = vecs[0].dest; result_in = vecs[0].res;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("lat_edge1_valid", 40'(wr_valid), 40'(0));
        @(posedge clk);
        #1;
        checkOutput("lat_edge2_valid", 40'(wr_valid), 40'(1));
        checkOutput("lat_edge2_data",  40'(wr_data),  40'(16'h4000));
        sendVec(1);
        sendVec(2);
        waitWrites(3);
        for (int i = 0; i < 3; i++)
            checkWrite($sformatf("inorder%0d", i), i, vecs[i].blk, vecs[i].dest, vecs[i].expData, vecs[i].expSat);
        checkOutput("inorder_count",   40'(wrQ.size()), 40'(3));
        checkOutput("inorder_next_id", 40'(next_id),    40'(3));

        // Out of order: id 2 must wait for ids 0 and 1
        doReset();
        sendVec(3);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ooo_hold_valid", 40'(wr_valid),   40'(0));
        checkOutput("ooo_hold_count", 40'(wrQ.size()), 40'(0));
        checkOutput("ooo_hold_next",  40'(next_id),    40'(0));
        sendVec(4);
        sendVec(5);
        waitWrites(3);
        checkWrite("ooo0", 0, vecs[4].blk, vecs[4].dest, vecs[4].expData, vecs[4].expSat);
        checkWrite("ooo1", 1, vecs[5].blk, vecs[5].dest, vecs[5].expData, vecs[5].expSat);
        checkWrite("ooo2", 2, vecs[3].blk, vecs[3].dest, vecs[3].expData, vecs[3].expSat);

        // Saturation at both rails and the exact negative boundary
        doReset();
        for (int i = 6; i <= 8; i++) sendVec(i);
        waitWrites(3);
        for (int i = 6; i <= 8; i++)
            checkWrite($sformatf("sat%0d", i), i - 6, vecs[i].blk, vecs[i].dest, vecs[i].expData, vecs[i].expSat);
        checkOutput("sat_count", 40'(sat_count), 40'(2));

        // Flag-0 retire and ID wrap: 20 ids, id 5 silent on the first pass
        doReset();
        for (int i = 0; i < 20; i++)
            applyStimulus(4'(i % 16), (i != 5), 8'(i), 4'(i % 16), 40'(i) << 15);
        waitWrites(19);
        checkOutput("wrap_count",   40'(wrQ.size()), 40'(19));
        checkOutput("wrap_next_id", 40'(next_id),    40'(4));
        begin
            int k = 0;
            for (int i = 0; i < 20; i++) begin
                if (i != 5) begin
                    checkOutput($sformatf("wrap_data%0d", i), (k < wrQ.size()) ? 40'(wrQ[k].data) : 40'hx, 40'(i));
                    k++;
                end
            end
        end

        // Backpressure, duplicate stall, enable freeze
        doReset();
        wr_ready = 1'b0;
        for (int i = 9; i <= 12; i++) sendVec(i);
        @(posedge clk);
        #1;
        checkOutput("bp_valid", 40'(wr_valid), 40'(1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_data_c%0d", c), 40'(wr_data), 40'(16'h000A));
            checkOutput($sformatf("bp_next_c%0d", c), 40'(next_id), 40'(1));
        end
        in_valid = 1'b1; commit_id_in = 4'd1; commit_flag_in = 1'b1;
        block_in = 8'hEE; dest_in = 4'hE; result_in = 40'h0;
        @(negedge clk);
        checkOutput("dup_in_ready", 40'(in_ready), 40'(0));
        commit_id_in = 4'd9;
        #1;
        checkOutput("free_in_ready", 40'(in_ready), 40'(1));
        in_valid = 1'b0;
        enable = 1'b0;
        wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("en_low_valid",    40'(wr_valid), 40'(1));
        checkOutput("en_low_next",     40'(next_id),  40'(1));
        checkOutput("en_low_in_ready", 40'(in_ready), 40'(0));
        enable = 1'b1;
        waitWrites(4);
        checkOutput("bp_count", 40'(wrQ.size()), 40'(4));
        for (int i = 9; i <= 12; i++)
            checkWrite($sformatf("bp%0d", i - 9), i - 9, vecs[i].blk, vecs[i].dest, vecs[i].expData, vecs[i].expSat);

        // Reset mid-stream discards the presented write and pending slots
        doReset();
        wr_ready = 1'b0;
        for (int i = 6; i <= 8; i++) sendVec(i);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mid_pre_valid", 40'(wr_valid),  40'(1));
        checkOutput("mid_pre_sat",   40'(sat_count), 40'(1));
        doReset();
        checkOutput("mid_valid",   40'(wr_valid),  40'(0));
        checkOutput("mid_next_id", 40'(next_id),   40'(0));
        checkOutput("mid_sat",     40'(sat_count), 40'(0));
        checkOutput("mid_data",    40'(wr_data),   40'(0));
        for (int i = 0; i < 16; i++) begin
            commit_id_in = 4'(i);
            #1;
            checkOutput($sformatf("mid_slot%0d_ready", i), 40'(in_ready), 40'(1));
        end
        wr_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
